// File: rtl/sqrt_state_register.sv
// Controller state machine of the square-root unit.
// Holds the 4-bit state code Q, a saturating loop-pass counter and a sticky
// forced-exit flag. Q feeds the downstream output-decode stage.
module sqrt_state_register #(
    parameter int unsigned ITER_W   = 5,
    parameter int unsigned MAX_ITER = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic              lt,
    output logic [3:0]        Q,
    output logic              Busy,
    output logic [ITER_W-1:0] iter,
    output logic              Ovf
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT1 = 4'd1,
        S_INIT2 = 4'd2,
        S_INIT3 = 4'd3,
        S_INIT4 = 4'd4,
        S_TEST  = 4'd5,
        S_LOOP1 = 4'd6,
        S_LOOP2 = 4'd7,
        S_LOOP3 = 4'd8,
        S_LOOP4 = 4'd9,
        S_LOOP5 = 4'd10,
        S_FIN1  = 4'd11,
        S_FIN2  = 4'd12,
        S_DONE  = 4'd13
    } state_e;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    // Kept as a plain vector so the two unused codes (1110, 1111) remain
    // representable and recover through the default branch.
    logic [3:0]        state_q;
    logic [ITER_W-1:0] iter_q;
    logic              ovf_q;

    // State sequencing, pass counting and forced-exit flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_e'(state_q))
                S_IDLE: begin
                    if (Start) begin
                        state_q <= S_INIT1;
                        iter_q  <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_INIT1: state_q <= S_INIT2;
                S_INIT2: state_q <= S_INIT3;
                S_INIT3: state_q <= S_INIT4;
                S_INIT4: state_q <= S_TEST;
                S_TEST: begin
                    if (lt) begin
                        state_q <= S_FIN1;
                    end else if (iter_q == MAX_ITER_C) begin
                        state_q <= S_FIN1;
                        ovf_q   <= 1'b1;
                    end else begin
                        state_q <= S_LOOP1;
                    end
                end
                S_LOOP1: state_q <= S_LOOP2;
                S_LOOP2: state_q <= S_LOOP3;
                S_LOOP3: state_q <= S_LOOP4;
                S_LOOP4: state_q <= S_LOOP5;
                S_LOOP5: begin
                    state_q <= S_TEST;
                    // Saturate rather than wrap; TEST normally exits first.
                    if (iter_q != MAX_ITER_C) begin
                        iter_q <= iter_q + ITER_W'(1);
                    end
                end
                S_FIN1: state_q <= S_FIN2;
                S_FIN2: state_q <= S_DONE;
                S_DONE: begin
                    if (!Start) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Q    = state_q;
    assign iter = iter_q;
    assign Ovf  = ovf_q;

    // Busy is a pure decode of the state register
    always_comb begin
        Busy = (state_q != S_IDLE) && (state_q != S_DONE);
    end

endmodule

// File: tb/tb_sqrt_state_register.sv
// Directed bench for sqrt_state_register with a reference model feeding a
// scoreboard queue, plus fixed-value checks at the key timing points.
module tb_sqrt_state_register;

    logic       clk;
    logic       rst_n;
    logic       Start;
    logic       lt;
    logic [3:0] Q;
    logic       Busy;
    logic [4:0] iter;
    logic       Ovf;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic [3:0] q;
        logic [4:0] it;
        logic       ovf;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic [3:0] m_q;
    logic [4:0] m_it;
    logic       m_ovf;

    sqrt_state_register #(
        .ITER_W  (5),
        .MAX_ITER(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Start(Start),
        .lt   (lt),
        .Q    (Q),
        .Busy (Busy),
        .iter (iter),
        .Ovf  (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the transition, queue the expectation, clock, compare.
    task automatic cyc(input logic s, input logic l);
        exp_t e;
        Start = s;
        lt    = l;
        case (m_q)
            4'd0: if (s) begin m_q = 4'd1; m_it = 5'd0; m_ovf = 1'b0; end
            4'd5: begin
                if (l)                m_q = 4'd11;
                else if (m_it == 5'd16) begin m_q = 4'd11; m_ovf = 1'b1; end
                else                  m_q = 4'd6;
            end
            4'd10: begin m_q = 4'd5; m_it = m_it + 5'd1; end
            4'd13: if (!s) m_q = 4'd0;
            4'd14, 4'd15: m_q = 4'd0;
            default: m_q = m_q + 4'd1;
        endcase
        e.q = m_q; e.it = m_it; e.ovf = m_ovf;
        e.busy = (m_q != 4'd0) && (m_q != 4'd13);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_Q",    32'(Q),    32'(e.q));
        check("sb_iter", 32'(iter), 32'(e.it));
        check("sb_Ovf",  32'(Ovf),  32'(e.ovf));
        check("sb_Busy", 32'(Busy), 32'(e.busy));
    endtask

    logic [3:0] seq0 [8];

    initial begin
        seq0 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd12, 4'd13};
        rst_n = 1'b0; Start = 1'b0; lt = 1'b0;
        m_q = 4'd0; m_it = 5'd0; m_ovf = 1'b0;
        #1;
        check("rst_Q",    32'(Q),    32'd0);
        check("rst_iter", 32'(iter), 32'd0);
        check("rst_Ovf",  32'(Ovf),  32'd0);
        check("rst_Busy", 32'(Busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // zero-pass operation, Start held through DONE
        for (int e = 0; e < 8; e++) begin
            cyc(1'b1, 1'b1);
            check("zp_seq", 32'(Q), 32'(seq0[e]));
        end
        check("zp_iter", 32'(iter), 32'd0);
        check("zp_Ovf",  32'(Ovf),  32'd0);
        // Start low on first DONE-sampled edge: DONE lasts one cycle
        cyc(1'b0, 1'b1);
        check("zp_exit", 32'(Q), 32'd0);

        // three-pass operation
        for (int e = 1; e <= 26; e++) begin
            cyc(1'b1, (m_q == 4'd5) && (m_it == 5'd3));
            if (e <= 25) check("tp_Busy", 32'(Busy), 32'd1);
        end
        check("tp_Q",    32'(Q),    32'd13);
        check("tp_iter", 32'(iter), 32'd3);
        check("tp_Ovf",  32'(Ovf),  32'd0);

        // done handshake: Start held for 10 cycles in DONE, then dropped
        for (int e = 0; e < 10; e++) begin
            cyc(1'b1, 1'b0);
            check("hs_hold", 32'(Q), 32'd13);
        end
        cyc(1'b0, 1'b0);
        check("hs_drop", 32'(Q), 32'd0);

        // forced exit after MAX_ITER passes
        for (int e = 1; e <= 104; e++) begin
            cyc(e == 1, 1'b0);
            if (e == 101) begin
                check("fe_test_Q", 32'(Q),    32'd5);
                check("fe_test_i", 32'(iter), 32'd16);
            end
            if (e == 102) begin
                check("fe_fin1_Q", 32'(Q),   32'd11);
                check("fe_fin1_O", 32'(Ovf), 32'd1);
            end
        end
        check("fe_Q",    32'(Q),    32'd13);
        check("fe_iter", 32'(iter), 32'd16);
        check("fe_Ovf",  32'(Ovf),  32'd1);
        cyc(1'b0, 1'b0);
        check("fe_idle_Ovf", 32'(Ovf), 32'd1);

        // illegal-state recovery, with iter=16 and Ovf=1 to be preserved
        force dut.state_q = 4'b1110;
        #1 release dut.state_q;
        m_q = 4'd14;
        check("ill14_Q", 32'(Q), 32'd14);
        cyc(1'b0, 1'b0);
        check("ill14_rec", 32'(Q), 32'd0);
        force dut.state_q = 4'b1111;
        #1 release dut.state_q;
        m_q = 4'd15;
        check("ill15_Q", 32'(Q), 32'd15);
        cyc(1'b0, 1'b0);
        check("ill15_rec",  32'(Q),    32'd0);
        check("ill15_iter", 32'(iter), 32'd16);
        check("ill15_Ovf",  32'(Ovf),  32'd1);

        // next Start clears Ovf and iter
        cyc(1'b1, 1'b0);
        check("clr_Q",    32'(Q),    32'd1);
        check("clr_Ovf",  32'(Ovf),  32'd0);
        check("clr_iter", 32'(iter), 32'd0);

        // run to mid-LOOP3 of the third pass, then async reset
        for (int e = 0; e < 19; e++) cyc(1'b0, 1'b0);
        check("mid_Q",    32'(Q),    32'd8);
        check("mid_iter", 32'(iter), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_Q",    32'(Q),    32'd0);
        check("arst_iter", 32'(iter), 32'd0);
        check("arst_Ovf",  32'(Ovf),  32'd0);
        check("arst_Busy", 32'(Busy), 32'd0);
        m_q = 4'd0; m_it = 5'd0; m_ovf = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int e = 0; e < 5; e++) begin
            cyc(1'b0, 1'b0);
            check("idle_hold", 32'(Q), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_state_register.md
# sqrt_state_register

- Controller state machine of the square-root unit.
- Holds the 4-bit state code `Q` and computes its next value from `Start`, the datapath comparison flag and an internal loop counter.
- `Q` drives the downstream combinational output-decode stage, which produces the register enables, bus selects, `sel_AU1`/`sel_AU2` and `Done`.
- Also reports busy status, the loop iteration count and an iteration-overflow flag.

## Interface

Parameters:
- `ITER_W`, default 5: width of the iteration counter.
- `MAX_ITER`, default 16: maximum loop passes before a forced exit. Legal range is 1 to 2^ITER_W − 1.

Ports:
- `clk`, input, 1 bit: single clock. Everything updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `Start`, input, 1 bit: request to start an operation. It doubles as the done-acknowledge (see DONE).
- `lt`, input, 1 bit: datapath comparison flag meaning "remainder < subtrahend". Sampled only in TEST.
- `Q`, output, 4 bits: current state code. Registered.
- `Busy`, output, 1 bit: high when `Q` is neither 0000 nor 1101. Combinational decode of `Q`.
- `iter`, output, ITER_W bits: number of completed loop passes. Registered.
- `Ovf`, output, 1 bit: sticky flag set on a forced exit. Registered.

## Operation

State encoding and transitions (the named state is the value of `Q`):
- 0000 IDLE
  - `Start`=1 → 0001. At this transition `iter` is cleared to 0 and `Ovf` is cleared to 0.
  - Otherwise stay in IDLE.
- 0001, 0010, 0011, 0100 INIT1–INIT4: unconditional advance to the next code.
- 0101 TEST, evaluated in priority order:
  - `lt`=1 → 1011. Normal exit.
  - `lt`=0 and `iter`==MAX_ITER → 1011, and set `Ovf`=1. Forced exit.
  - Otherwise → 0110.
- 0110–1010 LOOP1–LOOP5: unconditional advance. The exit from 1010 goes to 0101, and `iter` increments on that transition.
- 1011, 1100 FIN1, FIN2: unconditional advance. 1100 → 1101.
- 1101 DONE
  - Hold while `Start`=1.
  - `Start`=0 → 0000.
  - This makes a four-phase handshake: the downstream decode asserts `Done` in this state and keeps it asserted until `Start` drops.
- 1110, 1111 illegal: → 0000 on the next edge. `iter` and `Ovf` are unchanged.

Other rules:
- `lt` is ignored in every state except TEST.
- `Start` is ignored in every state except IDLE and DONE.
- `iter` saturates: it never wraps. Since TEST exits when `iter`==MAX_ITER, `iter` never exceeds MAX_ITER.
- `Ovf` holds its value until the next IDLE → INIT1 transition or reset.

## Timing

- Reset (asynchronous, immediate while `rst_n`=0):
  - `Q`=0000, `iter`=0, `Ovf`=0, `Busy`=0.
  - Reset mid-operation aborts from any state straight to IDLE with no partial result.
- Release: `Q` first leaves IDLE on the first rising edge after `rst_n`=1 on which `Start`=1.
- Latency with N loop passes:
  - Counting from the edge that samples `Start`=1 in IDLE, `Q` reaches 1101 after 8 + 6N edges.
  - Breakdown: 1 edge IDLE→INIT1, 4 edges INIT1→TEST, 6 edges per pass, then 3 edges TEST→FIN1→FIN2→DONE.
  - N=0 gives 8 cycles. N=MAX_ITER=16 gives 104 cycles.
- `lt` must be stable during the TEST cycle. The datapath updates it from the registers written in LOOP5 and INIT4.
- `Start` held high through DONE: `Q` stays at 1101 indefinitely.
- `Start` low on the first DONE cycle: `Q`=0000 one cycle later, so `Done` is visible for exactly 1 cycle.
- `Start` high in IDLE on the same edge that DONE → IDLE happens: no effect on that edge. The new operation begins on the following edge if `Start` is still 1.
- No combinational path from any input to `Q`. The only combinational output is `Busy`, which is decoded from `Q`.

## Test plan

1. Reset and idle hold:
   - Stimulus: assert `rst_n`=0 mid-LOOP3 (`Q`=1000, `iter`=2).
   - Required: `Q`=0000, `iter`=0, `Ovf`=0 immediately, with no clock edge. After release with `Start`=0 for 5 cycles, `Q` stays 0000.
2. Zero-pass operation:
   - Stimulus: `Start`=1, `lt`=1 throughout.
   - Required: `Q` sequence 0001, 0010, 0011, 0100, 0101, 1011, 1100, 1101. `Q`=1101 on edge 8, with `iter`=0 and `Ovf`=0.
3. Three-pass operation:
   - Stimulus: `lt`=0 at the first three TEST visits, `lt`=1 at the fourth.
   - Required: `Q`=1101 after 26 edges, `iter`=3, `Ovf`=0. `Busy`=1 from edge 1 through edge 25.
4. Forced exit:
   - Stimulus: MAX_ITER=16, `lt`=0 throughout.
   - Required: 16 passes, then exit to 1011 with `iter`=16. `Q`=1101 at edge 104 with `Ovf`=1. The next `Start` clears `Ovf` at IDLE → INIT1.
5. Done handshake:
   - Stimulus: hold `Start`=1 for 10 cycles in DONE, then drop it.
   - Required: `Q`=1101 for those 10 cycles, then 0000 one edge after `Start`=0. Repeat with `Start` already 0 on entry: DONE lasts exactly 1 cycle.
6. Illegal-state recovery:
   - Stimulus: force `Q`=1110, then separately `Q`=1111.
   - Required: `Q`=0000 on the next edge each time, with `iter` and `Ovf` unchanged.
